// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
// Sequencing controller for the shared iterative multiply/divide datapath.
// It accepts a one-cycle start pulse and latches the operation type. It then
// issues one operand-load cycle and N per-iteration step enables, tracks the
// iteration index, and finishes with a one-cycle result-ready pulse that
// carries an exception qualifier.
//
// Ports:
//   clk            - system clock, all state on rising edge
//   clr            - asynchronous active-high reset
//   ctrl_mult      - start multiply (one-cycle pulse, wins over ctrl_div)
//   ctrl_div       - start divide (one-cycle pulse)
//   div_by_zero    - divisor == 0, sampled in the start cycle
//   mult_ovf       - product overflow, observed while data_resultRDY is high
//   busy           - high in LOAD and RUN
//   load           - datapath captures operands / clears accumulator
//   step_en        - datapath performs one iteration
//   is_div         - latched operation select (0 = multiply, 1 = divide)
//   step           - 0-based index of the current iteration
//   data_resultRDY - result valid, one-cycle pulse
//   data_exception - exception qualifier, meaningful only with data_resultRDY
module multdiv_ctrl #(
    parameter int MULT_STEPS = 16,
    parameter int DIV_STEPS  = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             div_by_zero,
    input  logic             mult_ovf,
    output logic             busy,
    output logic             load,
    output logic             step_en,
    output logic             is_div,
    output logic [CNT_W-1:0] step,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);
    localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] step_next;
    logic             is_div_next;
    logic             dz_q;
    logic             dz_next;
    logic             start;
    logic             start_div;
    logic [CNT_W-1:0] last_step;

    assign start     = ctrl_mult | ctrl_div;
    // Multiply has priority when both start pulses arrive together.
    assign start_div = ctrl_div & ~ctrl_mult;
    assign last_step = is_div ? DIV_LAST : MULT_LAST;

    // State, iteration counter and latched operation registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            step   <= '0;
            is_div <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            state  <= state_next;
            step   <= step_next;
            is_div <= is_div_next;
            dz_q   <= dz_next;
        end
    end

    // Next-state and next-register computation.
    always_comb begin
        state_next  = state;
        step_next   = step;
        is_div_next = is_div;
        dz_next     = dz_q;
        if (start) begin
            // A start in any state discards whatever is in flight.
            state_next  = LOAD;
            is_div_next = start_div;
            dz_next     = div_by_zero & start_div;
            step_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                LOAD: begin
                    // A zero divisor needs no iterations; report it at once.
                    if (dz_q) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        step_next  = '0;
                    end
                end
                RUN: begin
                    // Counter holds at the last index so it never wraps.
                    if (step == last_step) begin
                        state_next = DONE;
                    end else begin
                        step_next = step + STEP_ONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Moore output decode; only the multiply overflow passes through live.
    always_comb begin
        busy           = 1'b0;
        load           = 1'b0;
        step_en        = 1'b0;
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                busy = 1'b1;
                load = 1'b1;
            end
            RUN: begin
                busy    = 1'b1;
                step_en = 1'b1;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                data_exception = is_div ? dz_q : mult_ovf;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed scenarios with a cycle-accurate
// expected-timeline model (load in cycle 1, step_en in 2..N+1, RDY in N+2).
module tb_multdiv_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       ctrl_mult = 1'b0;
    logic       ctrl_div = 1'b0;
    logic       div_by_zero = 1'b0;
    logic       mult_ovf = 1'b0;
    logic       busy;
    logic       load;
    logic       step_en;
    logic       is_div;
    logic [5:0] step;
    logic       data_resultRDY;
    logic       data_exception;

    int checks = 0;
    int passed = 0;

    multdiv_ctrl #(.MULT_STEPS(16), .DIV_STEPS(32), .CNT_W(6)) dut (
        .clk            (clk),
        .clr            (clr),
        .ctrl_mult      (ctrl_mult),
        .ctrl_div       (ctrl_div),
        .div_by_zero    (div_by_zero),
        .mult_ovf       (mult_ovf),
        .busy           (busy),
        .load           (load),
        .step_en        (step_en),
        .is_div         (is_div),
        .step           (step),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    always #5 clk = ~clk;

    // Expected {busy,load,step_en,rdy,exc,is_div} in cycle cc after the start edge.
    function automatic logic [5:0] exp_flags(int cc, int n, bit dz, bit dv, bit ovf);
        bit l, en, rdy, exc;
        l   = (cc == 1);
        en  = !dz && (cc >= 2) && (cc <= n + 1);
        rdy = dz ? (cc == 2) : (cc == n + 2);
        exc = rdy && (dv ? dz : ovf);
        return {l | en, l, en, rdy, exc, dv};
    endfunction

    // Expected step index in cycle cc after the start edge.
    function automatic logic [5:0] exp_step(int cc, int n, bit dz);
        if (dz || cc <= 1) return 6'd0;
        if (cc <= n + 1) return 6'(cc - 2);
        return 6'(n - 1);
    endfunction

    // Drive a start pulse across one rising edge; call and return on a negedge.
    task automatic pulse_start(input bit m, input bit d, input bit z);
        ctrl_mult   = m;
        ctrl_div    = d;
        div_by_zero = z;
        @(posedge clk);
        @(negedge clk);
        ctrl_mult   = 1'b0;
        ctrl_div    = 1'b0;
        div_by_zero = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        #1 clr = 1'b1;
        #1 got = {busy, load, step_en, is_div, data_resultRDY, data_exception, step};
        checks++;
        if (got !== 12'd0) $display("FAIL reset_init got=%b exp=%b", got, 12'd0);
        else passed++;
        @(negedge clk);
        clr = 1'b0;
        pulse_start(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (step_en !== 1'b1) $display("FAIL reset_pre_run step_en got=%b exp=1", step_en);
        else passed++;
        // Assert clr between edges: outputs must clear without a clock edge.
        @(posedge clk);
        #2 clr = 1'b1;
        #1 got = {busy, load, step_en, is_div, data_resultRDY, data_exception, step};
        checks++;
        if (got !== 12'd0) $display("FAIL reset_async got=%b exp=%b", got, 12'd0);
        else passed++;
        ctrl_mult = 1'b1;
        @(posedge clk);
        @(negedge clk);
        got = {busy, load, step_en, is_div, data_resultRDY, data_exception, step};
        checks++;
        if (got !== 12'd0) $display("FAIL reset_start_ignored got=%b exp=%b", got, 12'd0);
        else passed++;
        clr = 1'b0;
        ctrl_mult = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, load} !== 2'b00) $display("FAIL reset_release busy_load got=%b exp=00", {busy, load});
        else passed++;
    endtask

    task automatic test_mult(input bit ovf, input bit both);
        logic [5:0] got, ef, es;
        mult_ovf = ovf;
        pulse_start(1'b1, both, both);
        for (int c = 1; c <= 20; c++) begin
            ef  = exp_flags(c, 16, 1'b0, 1'b0, ovf);
            es  = exp_step(c, 16, 1'b0);
            got = {busy, load, step_en, data_resultRDY, data_exception, is_div};
            checks++;
            if (got !== ef) $display("FAIL mult(ovf=%0d,both=%0d) c=%0d flags got=%b exp=%b", ovf, both, c, got, ef);
            else passed++;
            checks++;
            if (step !== es) $display("FAIL mult(ovf=%0d,both=%0d) c=%0d step got=%0d exp=%0d", ovf, both, c, step, es);
            else passed++;
            @(negedge clk);
        end
        mult_ovf = 1'b0;
    endtask

    task automatic test_div(input bit dz);
        logic [5:0] got, ef, es;
        mult_ovf = 1'b1;
        pulse_start(1'b0, 1'b1, dz);
        for (int c = 1; c <= 36; c++) begin
            ef  = exp_flags(c, 32, dz, 1'b1, 1'b1);
            es  = exp_step(c, 32, dz);
            got = {busy, load, step_en, data_resultRDY, data_exception, is_div};
            checks++;
            if (got !== ef) $display("FAIL div(dz=%0d) c=%0d flags got=%b exp=%b", dz, c, got, ef);
            else passed++;
            checks++;
            if (step !== es) $display("FAIL div(dz=%0d) c=%0d step got=%0d exp=%0d", dz, c, step, es);
            else passed++;
            @(negedge clk);
        end
        mult_ovf = 1'b0;
    endtask

    task automatic test_abort();
        logic [5:0] got, ef, es;
        mult_ovf = 1'b1;
        pulse_start(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 46; c++) begin
            if (c <= 10) begin
                ef = exp_flags(c, 16, 1'b0, 1'b0, 1'b1);
                es = exp_step(c, 16, 1'b0);
            end else begin
                ef = exp_flags(c - 10, 32, 1'b0, 1'b1, 1'b1);
                es = exp_step(c - 10, 32, 1'b0);
            end
            got = {busy, load, step_en, data_resultRDY, data_exception, is_div};
            checks++;
            if (got !== ef) $display("FAIL abort c=%0d flags got=%b exp=%b", c, got, ef);
            else passed++;
            checks++;
            if (step !== es) $display("FAIL abort c=%0d step got=%0d exp=%0d", c, step, es);
            else passed++;
            if (c == 10) begin
                ctrl_div = 1'b1;
                @(posedge clk);
                @(negedge clk);
                ctrl_div = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        mult_ovf = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] got, ef, es;
        mult_ovf = 1'b1;
        pulse_start(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 54; c++) begin
            if (c <= 18) begin
                ef = exp_flags(c, 16, 1'b0, 1'b0, 1'b1);
                es = exp_step(c, 16, 1'b0);
            end else begin
                ef = exp_flags(c - 18, 32, 1'b0, 1'b1, 1'b1);
                es = exp_step(c - 18, 32, 1'b0);
            end
            got = {busy, load, step_en, data_resultRDY, data_exception, is_div};
            checks++;
            if (got !== ef) $display("FAIL b2b c=%0d flags got=%b exp=%b", c, got, ef);
            else passed++;
            checks++;
            if (step !== es) $display("FAIL b2b c=%0d step got=%0d exp=%0d", c, step, es);
            else passed++;
            if (c == 18) begin
                ctrl_div = 1'b1;
                @(posedge clk);
                @(negedge clk);
                ctrl_div = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        mult_ovf = 1'b0;
    endtask

    task automatic test_clr_mid();
        logic [11:0] got;
        pulse_start(1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if ({step_en, step} !== {1'b1, 6'd3}) $display("FAIL clr_mid_pre got=%b exp=%b", {step_en, step}, {1'b1, 6'd3});
        else passed++;
        clr = 1'b1;
        #1 got = {busy, load, step_en, is_div, data_resultRDY, data_exception, step};
        checks++;
        if (got !== 12'd0) $display("FAIL clr_mid_zero got=%b exp=%b", got, 12'd0);
        else passed++;
        @(negedge clk);
        clr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, load, step_en, data_resultRDY} !== 4'b0000)
                $display("FAIL clr_mid_quiet c=%0d got=%b exp=0000", c, {busy, load, step_en, data_resultRDY});
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mult(1'b0, 1'b0);
        test_mult(1'b1, 1'b0);
        test_div(1'b0);
        test_div(1'b1);
        test_mult(1'b0, 1'b1);
        test_abort();
        test_back_to_back();
        test_clr_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
